downscale_capture: RTL and testbench
====================================

# downscale_capture

Frame capture stage placed directly downstream of the image reader/filter stage. Accepts the downscaled pixel stream, in which HSYNC acts as a one-cycle pixel-valid strobe, and stores one full output frame of RGB888 pixels in an internal buffer. Once the frame is complete, it streams the frame out byte-by-byte in BMP pixel order (B, G, R) over a valid/ready port to the file-writer/output stage.

## Interface
- OUT_WIDTH, 480: output frame width in pixels.
- OUT_HEIGHT, 540: output frame height in pixels.
- NPIX, OUT_WIDTH*OUT_HEIGHT: pixels per frame (derived; do not override).
- HCLK  input  1  clock; all logic on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- VSYNC  input  1  frame-start indication from the upstream stage.
- HSYNC  input  1  pixel-valid strobe; DATA_* sampled when high.
- DATA_R0 / DATA_G0 / DATA_B0  input  8 each  pixel components.
- ctrl_done  input  1  upstream end-of-frame flag.
- rd_ready  input  1  downstream accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds a valid byte.
- rd_data  output  8  output byte.
- rd_last  output  1  high with the final byte of the frame.
- frame_done  output  1  one-cycle pulse after the final byte is accepted.
- busy  output  1  high in ST_CAPTURE or ST_DRAIN.
- overflow_err  output  1  sticky; HSYNC was seen outside ST_CAPTURE after the first frame start.
- short_err  output  1  sticky; ctrl_done arrived before NPIX pixels were captured.

## Operation
- Storage: NPIX words of 24 bits, holding {R,G,B}. One write per valid pixel. Synchronous read.
- Counters:
  - wr_addr: ceil(log2(NPIX)) bits.
  - rd_row: ceil(log2(OUT_HEIGHT)) bits.
  - rd_col: ceil(log2(OUT_WIDTH)) bits.
  - byte_sel: 0..2.
- FSM states: ST_IDLE, ST_CAPTURE, ST_DRAIN.
- ST_IDLE:
  - VSYNC=1 moves to ST_CAPTURE and clears wr_addr.
  - HSYNC is ignored here. It sets overflow_err only if a frame has previously started.
- ST_CAPTURE:
  - HSYNC=1 writes the pixel to mem[wr_addr] and increments wr_addr.
  - The write of pixel NPIX-1 moves the FSM to ST_DRAIN and resets the read counters.
  - ctrl_done=1 with fewer than NPIX pixels written sets short_err and returns to ST_IDLE. No drain occurs.
  - If HSYNC and ctrl_done arrive together on the last pixel, the pixel is written and the FSM moves to ST_DRAIN with no error.
- ST_DRAIN:
  - Pixel read order: row-major, starting at rd_row=0 (subject to the Configuration macro).
  - Byte order within a pixel: byte_sel 0 = B, 1 = G, 2 = R.
  - Handshake:
    - A byte transfers on any cycle with rd_valid & rd_ready.
    - While rd_valid=1 & rd_ready=0, rd_data and rd_last hold stable.
    - rd_valid never drops without a transfer.
  - rd_last=1 only on byte R of the final pixel in read order.
  - Transfer of the rd_last byte:
    - next cycle: rd_valid=0 and frame_done=1 for one cycle;
    - FSM returns to ST_IDLE.
  - VSYNC in this state is ignored. HSYNC in this state sets overflow_err.
- Errors clear only on reset.

## Timing
- Reset values: rd_valid 0, rd_data 0, rd_last 0, frame_done 0, busy 0, overflow_err 0, short_err 0, FSM ST_IDLE, all counters 0. Memory contents are undefined and are not cleared.
- Reset asserted mid-capture or mid-drain aborts immediately. The stream restarts only on a new VSYNC.
- VSYNC to ST_CAPTURE: 1 cycle. An HSYNC in the same cycle as the ST_IDLE→ST_CAPTURE transition is not captured.
- Capture pipeline accepts one pixel every cycle, with no bubbles required.
- Last pixel written → first rd_valid=1: exactly 2 cycles, covering the memory read and the output register.
- With rd_ready held high, one byte per cycle, so the drain takes 3*NPIX cycles.
- The pixel read is prefetched so that byte B of pixel n+1 follows byte R of pixel n with no bubble.

## Configuration
- BMP_ROW_FLIP_EN defined:
  - drain begins at rd_row=OUT_HEIGHT-1 and decrements to 0, giving bottom-up BMP row order;
  - columns stay ascending.
- BMP_ROW_FLIP_EN undefined:
  - drain begins at rd_row=0 and increments, giving top-down order;
  - output equals capture order.

## Test plan
All scenarios use OUT_WIDTH=4, OUT_HEIGHT=2. Pixel k is R=k, G=0x10+k, B=0x20+k.
- Reset: hold HRESETn=0 with HSYNC/VSYNC toggling → all outputs 0 and busy=0. Release, then pulse VSYNC → busy=1 after 1 cycle.
- Full frame, rd_ready=1, macro undefined:
  - stimulus: VSYNC, then 8 consecutive HSYNC;
  - rd_valid rises 2 cycles after the last HSYNC;
  - bytes are 0x20,0x10,0x00,0x21,0x11,0x01,…,0x27,0x17,0x07, with rd_last on 0x07;
  - frame_done pulses once, one cycle after the transfer of 0x07.
- BMP_ROW_FLIP_EN defined, same stimulus → first bytes 0x24,0x14,0x04 (pixel 4), and the last byte is 0x03 with rd_last=1.
- Backpressure:
  - stimulus: toggle rd_ready 1,0,0,1,… during drain;
  - rd_data is stable across stalled cycles;
  - exactly 24 transfers occur, with no duplicated or dropped bytes.
- Short frame:
  - stimulus: VSYNC, 5 HSYNC, then ctrl_done;
  - response: short_err=1, return to ST_IDLE, rd_valid never asserts.
- Overflow: HSYNC pulsed during drain → overflow_err=1 (sticky) and the drained data is unchanged from the full-frame case.

Source files
------------

// File: rtl/downscale_capture_if.sv
// Byte stream from the frame capture stage to the file writer.
// master drives valid/data/last, slave drives ready.
interface downscale_capture_if;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;

  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/downscale_capture.sv
// downscale_capture: buffers one downscaled RGB888 frame, then streams it out
// as B,G,R bytes over a valid/ready port.
// Optional macro BMP_ROW_FLIP_EN: drain rows bottom-up (BMP order) instead of top-down.
module downscale_capture #(
  parameter int OUT_WIDTH  = 480,
  parameter int OUT_HEIGHT = 540
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 VSYNC,
  input  logic                 HSYNC,
  input  logic [7:0]           DATA_R0,
  input  logic [7:0]           DATA_G0,
  input  logic [7:0]           DATA_B0,
  input  logic                 ctrl_done,
  downscale_capture_if.master  rd_bus,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overflow_err,
  output logic                 short_err
);
  localparam int NPIX = OUT_WIDTH * OUT_HEIGHT;
  localparam int AW   = (NPIX > 1)       ? $clog2(NPIX)       : 1;
  localparam int RW   = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int CW   = (OUT_WIDTH > 1)  ? $clog2(OUT_WIDTH)  : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} state_t;
  state_t state, state_nxt;

  logic [23:0]   mem [NPIX];
  logic [AW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] rd_row, row_next;
  logic [CW-1:0] rd_col;
  logic [1:0]    byte_sel;
  logic          started;
  logic [23:0]   rdata, cur_pix;
  logic          rdata_vld, rdata_last, rd_all, out_vld, cur_last;
  logic          pix_wr, last_wr, xfer, pix_done, frame_xfer, load_out, issue, issue_last;

`ifdef BMP_ROW_FLIP_EN
  localparam logic [RW-1:0] ROW_FIRST = RW'(OUT_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LAST  = '0;
  assign row_next = rd_row - RW'(1);
`else
  localparam logic [RW-1:0] ROW_FIRST = '0;
  localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_HEIGHT - 1);
  assign row_next = rd_row + RW'(1);
`endif

  assign pix_wr     = (state == ST_CAPTURE) && HSYNC;
  assign last_wr    = pix_wr && (wr_addr == AW'(NPIX - 1));
  assign xfer       = out_vld && rd_bus.rd_ready;
  assign pix_done   = xfer && (byte_sel == 2'd2);
  assign frame_xfer = pix_done && cur_last;
  // Output register takes the prefetched pixel when empty or when its R byte leaves.
  assign load_out   = rdata_vld && (!out_vld || pix_done);
  // Keep one pixel read ahead so B of pixel n+1 follows R of pixel n directly.
  assign issue      = (state == ST_DRAIN) && !rd_all && (!rdata_vld || load_out);
  assign issue_last = (rd_row == ROW_LAST) && (rd_col == CW'(OUT_WIDTH - 1));
  assign rd_addr    = AW'(32'(rd_row) * 32'(OUT_WIDTH) + 32'(rd_col));

  assign busy            = (state != ST_IDLE);
  assign rd_bus.rd_valid = out_vld;
  assign rd_bus.rd_last  = out_vld && cur_last && (byte_sel == 2'd2);
  assign rd_bus.rd_data  = (byte_sel == 2'd0) ? cur_pix[7:0]  :
                           (byte_sel == 2'd1) ? cur_pix[15:8] : cur_pix[23:16];

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (VSYNC) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (last_wr) state_nxt = ST_DRAIN;
                  else if (ctrl_done) state_nxt = ST_IDLE;
      ST_DRAIN:   if (frame_xfer) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Write pointer and sticky error flags
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_addr      <= '0;
      started      <= 1'b0;
      overflow_err <= 1'b0;
      short_err    <= 1'b0;
    end else begin
      if (state == ST_IDLE && VSYNC) begin
        wr_addr <= '0;
        started <= 1'b1;
      end else if (pix_wr) begin
        wr_addr <= wr_addr + AW'(1);
      end
      if (HSYNC && state != ST_CAPTURE && started) overflow_err <= 1'b1;
      if (state == ST_CAPTURE && ctrl_done && !last_wr) short_err <= 1'b1;
    end

  // Drain: read counters, prefetch slot and byte output register
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      rd_row <= '0; rd_col <= '0; rd_all <= 1'b0;
      rdata_vld <= 1'b0; rdata_last <= 1'b0;
      out_vld <= 1'b0; cur_pix <= '0; cur_last <= 1'b0; byte_sel <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_xfer;
      if (last_wr) begin
        rd_row <= ROW_FIRST; rd_col <= '0; rd_all <= 1'b0;
        rdata_vld <= 1'b0; out_vld <= 1'b0; byte_sel <= '0;
      end else begin
        if (issue) begin
          rdata_vld  <= 1'b1;
          rdata_last <= issue_last;
          rd_all     <= issue_last;
          if (rd_col == CW'(OUT_WIDTH - 1)) begin
            rd_col <= '0;
            rd_row <= row_next;
          end else begin
            rd_col <= rd_col + CW'(1);
          end
        end else if (load_out) begin
          rdata_vld <= 1'b0;
        end
        if (load_out) begin
          cur_pix  <= rdata;
          cur_last <= rdata_last;
          byte_sel <= '0;
          out_vld  <= 1'b1;
        end else if (pix_done) begin
          out_vld  <= 1'b0;
          byte_sel <= '0;
        end else if (xfer) begin
          byte_sel <= byte_sel + 2'd1;
        end
      end
    end

  // Pixel buffer: one write per captured pixel, registered read for the drain
  always_ff @(posedge HCLK) begin
    if (pix_wr) mem[wr_addr] <= {DATA_R0, DATA_G0, DATA_B0};
    if (issue)  rdata <= mem[rd_addr];
  end
endmodule

// File: tb/tb_downscale_capture.sv
// Bench for downscale_capture with a 4x2 frame; expected byte stream is built
// from the pixel arrays in BMP (B,G,R) order and row order chosen by BMP_ROW_FLIP_EN.
module tb_downscale_capture;
  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
`ifdef BMP_ROW_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic       HCLK = 1'b0, HRESETn = 1'b0, VSYNC = 1'b0, HSYNC = 1'b0, ctrl_done = 1'b0;
  logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic       frame_done, busy, overflow_err, short_err;

  downscale_capture_if rd_bus();

  downscale_capture #(.OUT_WIDTH(W), .OUT_HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0), .ctrl_done(ctrl_done),
    .rd_bus(rd_bus), .frame_done(frame_done), .busy(busy),
    .overflow_err(overflow_err), .short_err(short_err));

  always #5 HCLK = ~HCLK;

  int n_checks = 0, n_fail = 0;
  logic [7:0] pr[N], pg[N], pb[N];
  logic [7:0] exp_d[$], got_d[$];
  bit         got_l[$];
  int         first_vld, last_cyc, fd_cnt, stall_viol;
  bit         fd_after, vld_after;

  function automatic void set_pattern();
    for (int k = 0; k < N; k++) begin
      pr[k] = 8'(k); pg[k] = 8'(8'h10 + k); pb[k] = 8'(8'h20 + k);
    end
  endfunction

  function automatic void build_expected();
    exp_d.delete();
    for (int r = 0; r < H; r++) begin
      int row = FLIP ? (H - 1 - r) : r;
      for (int c = 0; c < W; c++) begin
        exp_d.push_back(pb[row*W + c]);
        exp_d.push_back(pg[row*W + c]);
        exp_d.push_back(pr[row*W + c]);
      end
    end
  endfunction

  // VSYNC, then n back-to-back pixels; returns on the negedge after the last pixel was sampled.
  task automatic send_frame(input int n, input bit done_on_last);
    VSYNC = 1'b1;
    @(negedge HCLK);
    VSYNC = 1'b0;
    for (int i = 0; i < n; i++) begin
      HSYNC = 1'b1; DATA_R0 = pr[i]; DATA_G0 = pg[i]; DATA_B0 = pb[i];
      ctrl_done = done_on_last && (i == n - 1);
      @(negedge HCLK);
    end
    HSYNC = 1'b0; ctrl_done = 1'b0;
  endtask

  // Sink: mode 0 ready=1, mode 1 ready 1,0,0 repeating, mode 2 random.
  task automatic collect(input int mode, input bit inject);
    int cyc = 0;
    bit done = 0, prev_stall = 0, r;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0;
    got_d.delete(); got_l.delete();
    first_vld = -1; last_cyc = -1; fd_cnt = 0; stall_viol = 0; fd_after = 0; vld_after = 1;
    while (!done && cyc < 1000) begin
      if (frame_done) fd_cnt++;
      if (last_cyc >= 0 && cyc == last_cyc + 1) begin
        fd_after = frame_done; vld_after = rd_bus.rd_valid;
      end
      if (rd_bus.rd_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall && (!rd_bus.rd_valid || rd_bus.rd_data !== prev_d || rd_bus.rd_last !== prev_l))
        stall_viol++;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      rd_bus.rd_ready = r;
      HSYNC = inject && first_vld >= 0 && cyc == first_vld + 3;
      DATA_R0 = 8'hEE; DATA_G0 = 8'hDD; DATA_B0 = 8'hCC;
      if (rd_bus.rd_valid && r) begin
        got_d.push_back(rd_bus.rd_data);
        got_l.push_back(rd_bus.rd_last);
        if (rd_bus.rd_last) last_cyc = cyc;
      end
      prev_stall = rd_bus.rd_valid && !r;
      prev_d = rd_bus.rd_data; prev_l = rd_bus.rd_last;
      if (last_cyc >= 0 && cyc >= last_cyc + 3) done = 1;
      @(negedge HCLK);
      cyc++;
    end
    rd_bus.rd_ready = 1'b0; HSYNC = 1'b0;
    n_checks++;
    if (last_cyc < 0) begin n_fail++; $display("FAIL drain_timeout: no rd_last within 1000 cycles"); end
  endtask

  task automatic check_stream(input string tag);
    n_checks++;
    if (got_d.size() != exp_d.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d bytes, want %0d", tag, got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1)) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got %h last=%0d, want %h last=%0d", tag, i, got_d[i], got_l[i],
                 exp_d[i], (i == exp_d.size() - 1));
      end
    end
    n_checks++;
    if (fd_cnt != 1 || fd_after !== 1'b1 || vld_after !== 1'b0) begin
      n_fail++; $display("FAIL %s_frame_done: pulses=%0d after=%0d valid_after=%0d, want 1 1 0",
                         tag, fd_cnt, fd_after, vld_after);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%0d want 0", tag, busy); end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      VSYNC = (i % 2 == 1); HSYNC = (i % 2 == 0);
      @(negedge HCLK);
      n_checks++;
      if ({rd_bus.rd_valid, rd_bus.rd_data, rd_bus.rd_last, frame_done, busy, overflow_err, short_err} !== 14'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: valid=%0d data=%h last=%0d fd=%0d busy=%0d ovf=%0d short=%0d, want all 0",
                 rd_bus.rd_valid, rd_bus.rd_data, rd_bus.rd_last, frame_done, busy, overflow_err, short_err);
      end
    end
    VSYNC = 1'b0; HSYNC = 1'b0; HRESETn = 1'b1;
    @(negedge HCLK);
    HSYNC = 1'b1;
    @(negedge HCLK);
    HSYNC = 1'b0;
    n_checks++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL idle_hsync_before_start: ovf=%0d want 0", overflow_err); end
    VSYNC = 1'b1;
    @(negedge HCLK);
    VSYNC = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL vsync_to_capture: busy=%0d want 1", busy); end
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_abort: busy=%0d want 0", busy); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_full_frame();
    set_pattern(); build_expected();
    send_frame(N, 1'b0);
    collect(0, 1'b0);
    n_checks++;
    if (first_vld != 2) begin n_fail++; $display("FAIL first_valid_latency: got %0d cycles want 2", first_vld); end
    n_checks++;
    if (got_d.size() > 0 && got_d[0] !== (FLIP ? 8'h24 : 8'h20)) begin
      n_fail++; $display("FAIL first_byte: got %h want %h", got_d[0], FLIP ? 8'h24 : 8'h20);
    end
    n_checks++;
    if (got_d.size() > 0 && got_d[got_d.size()-1] !== (FLIP ? 8'h03 : 8'h07)) begin
      n_fail++; $display("FAIL last_byte: got %h want %h", got_d[got_d.size()-1], FLIP ? 8'h03 : 8'h07);
    end
    check_stream("full");
    n_checks++;
    if (overflow_err !== 1'b0 || short_err !== 1'b0) begin
      n_fail++; $display("FAIL full_errors: ovf=%0d short=%0d want 0 0", overflow_err, short_err);
    end
  endtask

  task automatic test_backpressure();
    set_pattern(); build_expected();
    send_frame(N, 1'b0);
    collect(1, 1'b0);
    n_checks++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: %0d unstable stalled cycles want 0", stall_viol); end
    check_stream("bp");
  endtask

  task automatic test_random_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        pr[k] = 8'($urandom); pg[k] = 8'($urandom); pb[k] = 8'($urandom);
      end
      build_expected();
      send_frame(N, 1'b1);   // ctrl_done together with the last pixel is not an error
      collect(2, 1'b0);
      check_stream("rand");
      n_checks++;
      if (short_err !== 1'b0) begin n_fail++; $display("FAIL done_on_last: short=%0d want 0", short_err); end
    end
  endtask

  task automatic test_overflow();
    set_pattern(); build_expected();
    send_frame(N, 1'b0);
    collect(0, 1'b1);
    check_stream("ovf");
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_set: ovf=%0d want 1", overflow_err); end
    repeat (5) @(negedge HCLK);
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: ovf=%0d want 1", overflow_err); end
  endtask

  task automatic test_short_frame();
    int vld_seen = 0;
    set_pattern();
    n_checks++;
    if (short_err !== 1'b0) begin n_fail++; $display("FAIL short_pre: short=%0d want 0", short_err); end
    send_frame(5, 1'b0);
    ctrl_done = 1'b1;
    @(negedge HCLK);
    ctrl_done = 1'b0;
    n_checks++;
    if (short_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL short_frame: short=%0d busy=%0d want 1 0", short_err, busy);
    end
    rd_bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rd_bus.rd_valid) vld_seen++;
      @(negedge HCLK);
    end
    rd_bus.rd_ready = 1'b0;
    n_checks++;
    if (vld_seen != 0) begin n_fail++; $display("FAIL short_no_drain: valid cycles=%0d want 0", vld_seen); end
  endtask

  initial begin
    rd_bus.rd_ready = 1'b0;
    @(negedge HCLK);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_back_to_back();
    test_overflow();
    test_short_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
